// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit for the MEM stage.
// Byte/half/word loads and stores against a DATA_WIDTH-wide cache, with byte
// enables, store-data lane replication, load alignment and sign/zero extension.
// A three-state FSM (IDLE/ACCESS/RESP) holds the cache request across
// cache_waitrequest and stalls upstream. Non-memory ops pass straight through.
// Optional feature macro: MEM_LSU_ALIGN_CHECK_EN. When defined, misaligned
// half/word accesses raise addr_error and are not sent to the cache. When
// undefined, the misaligned low address bits are masked off.
module mem_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clock,
   input  logic                      reset_n,
   output logic                      cache_rd,
   output logic                      cache_wr,
   output logic [ADDR_WIDTH-1:0]     cache_addr,
   output logic [DATA_WIDTH/8-1:0]   cache_be,
   output logic [DATA_WIDTH-1:0]     cache_wr_data,
   input  logic [DATA_WIDTH-1:0]     cache_data,
   input  logic                      cache_waitrequest,
   input  logic                      load_inst,
   input  logic                      store_inst,
   input  logic [1:0]                mem_size,
   input  logic                      load_unsigned,
   input  logic [31:0]               agu_result,
   input  logic [31:0]               store_data,
   input  logic [4:0]                dest_reg,
   input  logic                      dest_reg_valid,
   output logic [31:0]               result,
   output logic [4:0]                result_dest_reg,
   output logic                      result_dest_valid,
   output logic                      stall,
   output logic                      addr_error
);

   localparam int BE = DATA_WIDTH / 8;
   localparam int L  = $clog2(BE);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Clear the low address bits a half or word access ignores.
   function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] r;
      r = a;
      if (sz == SZ_HALF)      r[0]   = 1'b0;
      else if (sz == SZ_WORD) r[1:0] = 2'b00;
      return r;
   endfunction

   // Byte-lane enables for the access size at lane offset o.
   function automatic logic [BE-1:0] byte_enables(input logic [L-1:0] o, input logic [1:0] sz);
      logic [BE-1:0] be;
      case (sz)
         SZ_BYTE: be = BE'(1)     << o;
         SZ_HALF: be = BE'(3)     << (o & ~L'(1));
         default: be = BE'(4'hF)  << (o & ~L'(3));
      endcase
      return be;
   endfunction

   // Replicate the store operand across every lane of the cache word.
   function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [31:0] sd, input logic [1:0] sz);
      logic [DATA_WIDTH-1:0] w;
      case (sz)
         SZ_BYTE: w = {BE{sd[7:0]}};
         SZ_HALF: w = {(BE/2){sd[15:0]}};
         default: w = {(BE/4){sd}};
      endcase
      return w;
   endfunction

   // Shift the addressed lane down to bit 0 and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [DATA_WIDTH-1:0] d,
                                                input logic [L-1:0] o,
                                                input logic [1:0] sz,
                                                input logic uns);
      logic [31:0]        low;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      low = 32'(d >> {o, 3'b000});
      b   = $signed(low[7:0]);
      h   = $signed(low[15:0]);
      case (sz)
         SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = low;
      endcase
      return r;
   endfunction

   logic                  mem_op;
   logic [1:0]            size_eff;
   logic [31:0]           addr_m;
   logic [31:0]           line_addr;
   logic [L-1:0]          lane_off;
   logic                  align_err;
   logic                  accept;

   assign mem_op    = load_inst | store_inst;
   assign size_eff  = (mem_size == 2'b11) ? SZ_WORD : mem_size;
   assign addr_m    = align_addr(agu_result, size_eff);
   assign line_addr = addr_m >> L;
   assign lane_off  = addr_m[L-1:0];

`ifdef MEM_LSU_ALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = ((size_eff == SZ_HALF) && agu_result[0]) ||
                       ((size_eff == SZ_WORD) && (agu_result[1:0] != 2'b00));
   assign align_err  = (state_q == IDLE) && mem_op && misaligned;
`else
   assign align_err  = 1'b0;
`endif

   assign accept = (state_q == IDLE) && mem_op && !align_err;

   // Request registers (p1 = captured at accept, driven during ACCESS)
   logic                  req_rd_p1;
   logic                  req_wr_p1;
   logic [ADDR_WIDTH-1:0] addr_p1;
   logic [BE-1:0]         be_p1;
   logic [DATA_WIDTH-1:0] wdata_p1;
   logic [L-1:0]          off_p1;
   logic [1:0]            size_p1;
   logic                  uns_p1;
   logic [4:0]            dest_p1;
   logic                  dvalid_p1;
   logic [31:0]           result_p1;

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Request direction flags; cleared by reset so an abandoned access is forgotten.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         req_rd_p1 <= 1'b0;
         req_wr_p1 <= 1'b0;
      end else if (accept) begin
         req_rd_p1 <= load_inst;
         req_wr_p1 <= !load_inst;
      end
   end

   // Request datapath capture at accept; outputs are gated by state so no reset needed.
   always_ff @(posedge clock) begin
      if (accept) begin
         addr_p1   <= ADDR_WIDTH'(line_addr);
         be_p1     <= byte_enables(lane_off, size_eff);
         wdata_p1  <= store_lanes(store_data, size_eff);
         off_p1    <= lane_off;
         size_p1   <= size_eff;
         uns_p1    <= load_unsigned;
         dest_p1   <= dest_reg;
         dvalid_p1 <= dest_reg_valid;
      end
   end

   // Load result capture when the cache returns data.
   always_ff @(posedge clock) begin
      if (!reset_n)
         result_p1 <= 32'd0;
      else if ((state_q == ACCESS) && !cache_waitrequest && req_rd_p1)
         result_p1 <= load_extract(cache_data, off_p1, size_p1, uns_p1);
   end

   // Next-state and output decode.
   always_comb begin
      state_d           = state_q;
      cache_rd          = 1'b0;
      cache_wr          = 1'b0;
      cache_addr        = '0;
      cache_be          = '0;
      cache_wr_data     = '0;
      result            = agu_result;
      result_dest_reg   = dest_reg;
      result_dest_valid = 1'b0;
      stall             = 1'b0;
      addr_error        = align_err;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = ACCESS;
               stall   = 1'b1;
            end else if (!mem_op) begin
               result_dest_valid = dest_reg_valid;
            end
         end
         ACCESS: begin
            cache_rd        = req_rd_p1;
            cache_wr        = req_wr_p1;
            cache_addr      = addr_p1;
            cache_be        = be_p1;
            cache_wr_data   = wdata_p1;
            result          = result_p1;
            result_dest_reg = dest_p1;
            stall           = 1'b1;
            if (!cache_waitrequest) state_d = RESP;
         end
         RESP: begin
            result            = result_p1;
            result_dest_reg   = dest_p1;
            result_dest_valid = req_rd_p1 & dvalid_p1;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu; a 32-bit and a 64-bit instance run
// the same instruction sequence in lockstep. Misaligned-access expectations
// follow MEM_LSU_ALIGN_CHECK_EN.
module tb_mem_lsu;

   logic        clock;
   logic        reset_n;
   logic        cache_waitrequest;
   logic        load_inst;
   logic        store_inst;
   logic [1:0]  mem_size;
   logic        load_unsigned;
   logic [31:0] agu_result;
   logic [31:0] store_data;
   logic [4:0]  dest_reg;
   logic        dest_reg_valid;
   logic [31:0] cd32;
   logic [63:0] cd64;

   logic        a_rd, a_wr, a_dv, a_stall, a_err;
   logic [31:0] a_addr, a_wdata, a_result;
   logic [3:0]  a_be;
   logic [4:0]  a_dest;

   logic        b_rd, b_wr, b_dv, b_stall, b_err;
   logic [31:0] b_addr, b_result;
   logic [63:0] b_wdata;
   logic [7:0]  b_be;
   logic [4:0]  b_dest;

   int total = 0;
   int bad   = 0;

   mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut32 (
      .clock(clock), .reset_n(reset_n),
      .cache_rd(a_rd), .cache_wr(a_wr), .cache_addr(a_addr), .cache_be(a_be),
      .cache_wr_data(a_wdata), .cache_data(cd32), .cache_waitrequest(cache_waitrequest),
      .load_inst(load_inst), .store_inst(store_inst), .mem_size(mem_size),
      .load_unsigned(load_unsigned), .agu_result(agu_result), .store_data(store_data),
      .dest_reg(dest_reg), .dest_reg_valid(dest_reg_valid),
      .result(a_result), .result_dest_reg(a_dest), .result_dest_valid(a_dv),
      .stall(a_stall), .addr_error(a_err)
   );

   mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut64 (
      .clock(clock), .reset_n(reset_n),
      .cache_rd(b_rd), .cache_wr(b_wr), .cache_addr(b_addr), .cache_be(b_be),
      .cache_wr_data(b_wdata), .cache_data(cd64), .cache_waitrequest(cache_waitrequest),
      .load_inst(load_inst), .store_inst(store_inst), .mem_size(mem_size),
      .load_unsigned(load_unsigned), .agu_result(agu_result), .store_data(store_data),
      .dest_reg(dest_reg), .dest_reg_valid(dest_reg_valid),
      .result(b_result), .result_dest_reg(b_dest), .result_dest_valid(b_dv),
      .stall(b_stall), .addr_error(b_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mem_in(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rdv);
      load_inst      = ld;
      store_inst     = st;
      mem_size       = sz;
      load_unsigned  = uns;
      agu_result     = a;
      store_data     = sd;
      dest_reg       = rd;
      dest_reg_valid = rdv;
   endtask

   initial begin
      reset_n = 1'b0;
      cache_waitrequest = 1'b0;
      cd32 = '0;
      cd64 = '0;
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;
      tick;
      // reset state
      chk("rst_rd",    a_rd,    1'b0);
      chk("rst_wr",    a_wr,    1'b0);
      chk("rst_be",    a_be,    4'h0);
      chk("rst_stall", a_stall, 1'b0);
      chk("rst_dv",    a_dv,    1'b0);
      chk("rst_err",   a_err,   1'b0);
      reset_n = 1'b1;

      // non-memory pass-through
      mem_in(0, 0, 2'b00, 0, 32'h1234_5678, 32'h0, 5'd5, 1);
      #1;
      chk("alu_result", a_result, 32'h1234_5678);
      chk("alu_dest",   a_dest,   5'd5);
      chk("alu_dv",     a_dv,     1'b1);
      chk("alu_stall",  a_stall,  1'b0);
      tick;

      // store word 0xDEADBEEF to 0x100
      mem_in(0, 1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF, 5'd0, 0);
      #1;
      chk("sw_stall0", a_stall, 1'b1);
      tick;
      chk("sw_wr",     a_wr,    1'b1);
      chk("sw_rd",     a_rd,    1'b0);
      chk("sw_addr",   a_addr,  32'h40);
      chk("sw_be",     a_be,    4'hF);
      chk("sw_wdata",  a_wdata, 32'hDEAD_BEEF);
      chk("sw_stall1", a_stall, 1'b1);
      chk("sw64_addr", b_addr,  32'h20);
      chk("sw64_be",   b_be,    8'h0F);
      chk("sw64_wdata", b_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
      tick;
      chk("sw_stall2", a_stall, 1'b0);
      chk("sw_resp_wr", a_wr,   1'b0);
      chk("sw_resp_dv", a_dv,   1'b0);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load byte signed from 0x103
      cd32 = 32'h80FF_1234;
      cd64 = 64'h0000_0000_80FF_1234;
      mem_in(1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd7, 1);
      #1;
      chk("lb_stall0", a_stall, 1'b1);
      chk("lb_dv0",    a_dv,    1'b0);
      tick;
      chk("lb_rd",     a_rd,    1'b1);
      chk("lb_be",     a_be,    4'h8);
      chk("lb_addr",   a_addr,  32'h40);
      chk("lb64_be",   b_be,    8'h08);
      tick;
      chk("lb_result", a_result, 32'hFFFF_FF80);
      chk("lb_dest",   a_dest,   5'd7);
      chk("lb_dv",     a_dv,     1'b1);
      chk("lb64_result", b_result, 32'hFFFF_FF80);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load byte unsigned from 0x103
      mem_in(1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd7, 1);
      tick;
      tick;
      chk("lbu_result", a_result, 32'h0000_0080);
      chk("lbu64_result", b_result, 32'h0000_0080);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // store half 0xA55A to 0x106
      mem_in(0, 1, 2'b01, 0, 32'h106, 32'h0000_A55A, 5'd0, 0);
      tick;
      chk("sh_be",      a_be,    4'hC);
      chk("sh_addr",    a_addr,  32'h41);
      chk("sh_wdata",   a_wdata, 32'hA55A_A55A);
      chk("sh64_be",    b_be,    8'hC0);
      chk("sh64_addr",  b_addr,  32'h20);
      chk("sh64_wdata", b_wdata, 64'hA55A_A55A_A55A_A55A);
      tick;
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load half signed from 0x102
      cd32 = 32'h8001_0000;
      cd64 = 64'h0000_0000_8001_0000;
      mem_in(1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd3, 1);
      tick;
      chk("lh_be", a_be, 4'hC);
      tick;
      chk("lh_result",   a_result, 32'hFFFF_8001);
      chk("lh64_result", b_result, 32'hFFFF_8001);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load word from 0x104 (upper half of a 64-bit line)
      cd32 = 32'h5566_7788;
      cd64 = 64'h1122_3344_5566_7788;
      mem_in(1, 0, 2'b10, 0, 32'h104, 32'h0, 5'd4, 1);
      tick;
      chk("lw_addr",   a_addr, 32'h41);
      chk("lw64_be",   b_be,   8'hF0);
      tick;
      chk("lw_result",   a_result, 32'h5566_7788);
      chk("lw64_result", b_result, 32'h1122_3344);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load word with four wait cycles
      cd32 = 32'h0;
      cd64 = 64'h0;
      cache_waitrequest = 1'b1;
      mem_in(1, 0, 2'b10, 0, 32'h200, 32'h0, 5'd9, 1);
      tick;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            cache_waitrequest = 1'b0;
            cd32 = 32'hCAFE_F00D;
            cd64 = 64'h0BAD_0BAD_CAFE_F00D;
         end
         #1;
         chk($sformatf("wait_rd%0d", i),    a_rd,    1'b1);
         chk($sformatf("wait_addr%0d", i),  a_addr,  32'h80);
         chk($sformatf("wait_stall%0d", i), a_stall, 1'b1);
         tick;
      end
      chk("wait_result",   a_result, 32'hCAFE_F00D);
      chk("wait_dv",       a_dv,     1'b1);
      chk("wait_dest",     a_dest,   5'd9);
      chk("wait_stall",    a_stall,  1'b0);
      chk("wait64_result", b_result, 32'hCAFE_F00D);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // reset while in ACCESS
      mem_in(1, 0, 2'b10, 0, 32'h300, 32'h0, 5'd2, 1);
      tick;
      chk("rsta_rd_before", a_rd, 1'b1);
      reset_n = 1'b0;
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;
      chk("rsta_rd",    a_rd,    1'b0);
      chk("rsta_stall", a_stall, 1'b0);
      reset_n = 1'b1;

      // store after reset: RESP shows the cleared result register
      mem_in(0, 1, 2'b10, 0, 32'h104, 32'h0102_0304, 5'd0, 0);
      tick;
      chk("post_sw_wr", a_wr, 1'b1);
      tick;
      chk("post_sw_result", a_result, 32'h0);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // load after reset proceeds normally
      cd32 = 32'h0BAD_F00D;
      mem_in(1, 0, 2'b10, 0, 32'h104, 32'h0, 5'd6, 1);
      tick;
      chk("post_lw_rd", a_rd, 1'b1);
      tick;
      chk("post_lw_result", a_result, 32'h0BAD_F00D);
      chk("post_lw_dv",     a_dv,     1'b1);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;

      // misaligned word load at 0x102
      mem_in(1, 0, 2'b10, 0, 32'h102, 32'h0, 5'd8, 1);
      #1;
`ifdef MEM_LSU_ALIGN_CHECK_EN
      chk("mis_err",    a_err,    1'b1);
      chk("mis_stall",  a_stall,  1'b0);
      chk("mis_result", a_result, 32'h102);
      chk("mis_dv",     a_dv,     1'b0);
      tick;
      chk("mis_rd",     a_rd,     1'b0);
      chk("mis_err1",   a_err,    1'b1);
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;
`else
      chk("mis_err",    a_err,    1'b0);
      chk("mis_stall",  a_stall,  1'b1);
      tick;
      chk("mis_rd",     a_rd,     1'b1);
      chk("mis_be",     a_be,     4'hF);
      chk("mis_addr",   a_addr,   32'h40);
      chk("mis64_be",   b_be,     8'h0F);
      chk("mis64_addr", b_addr,   32'h20);
      tick;
      mem_in(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
      tick;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
